// File: rtl/keypad_pkg.sv
// Shared types, key map and helpers for the 4x4 keypad scan controller.
package keypad_pkg;

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StHeld,
        StRelease
    } kp_state_t;

    // Indexed by {row, col}: row 0 is "1 2 3 A", row 3 is "E 0 F D".
    localparam logic [3:0] KeyMap [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic logic one_hot_valid(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    // Only meaningful when one_hot_valid(v) holds.
    function automatic logic [1:0] one_hot_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad pin and key-event bundle between the controller and its neighbours.
interface keypad_if;

    logic [3:0] rows;
    logic [3:0] col_keys;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  rows,
        output col_keys,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output rows,
        input  col_keys,
        input  key_code,
        input  key_valid,
        input  key_held
    );

endinterface

// File: rtl/scan_tick.sv
// Free-running divider producing a one-cycle tick every ScanDiv clocks.
module scan_tick #(
    parameter int unsigned ScanDiv = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick_o
);

    localparam int unsigned CntW = (ScanDiv > 1) ? $clog2(ScanDiv) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(ScanDiv - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CntLast);

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_controller.sv
// Press-aware column scanner with press/release debounce for a 4x4 matrix keypad.
module keypad_controller
    import keypad_pkg::*;
#(
    parameter int unsigned ScanDiv       = 50000,
    parameter int unsigned DebounceTicks = 4
) (
    input  logic     clk,
    input  logic     reset,
    keypad_if.master kp_if
);

    localparam int unsigned CntW = $clog2(DebounceTicks + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(DebounceTicks);
    localparam logic [CntW-1:0] CntLast = CntW'(DebounceTicks - 1);

    logic            tick;
    logic [3:0]      rows_meta_q;
    logic [3:0]      rows_s_q;
    kp_state_t       state_q, state_d;
    logic [1:0]      col_idx_q, col_idx_d;
    logic [1:0]      row_idx_q, row_idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      key_code_q, key_code_d;
    logic            key_valid_q, key_valid_d;

    logic            row_match;
    logic            row_hit;
    logic            cnt_done;
    logic [CntW-1:0] cnt_inc;

    scan_tick #(
        .ScanDiv (ScanDiv)
    ) u_scan_tick (
        .clk    (clk),
        .reset  (reset),
        .tick_o (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rows_meta_q <= '0;
            rows_s_q    <= '0;
        end else begin
            rows_meta_q <= kp_if.rows;
            rows_s_q    <= rows_meta_q;
        end
    end

    assign row_match = (rows_s_q == (4'b0001 << row_idx_q));
    assign row_hit   = rows_s_q[row_idx_q];
    // This tick is the DebounceTicks-th qualifying one.
    assign cnt_done  = (cnt_q >= CntLast);
    assign cnt_inc   = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StScan;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            cnt_q       <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        row_idx_d = row_idx_q;
        cnt_d     = cnt_q;
        if (tick) begin
            unique case (state_q)
                StScan: begin
                    if (one_hot_valid(rows_s_q)) begin
                        row_idx_d = one_hot_index(rows_s_q);
                        cnt_d     = '0;
                        state_d   = StDebounce;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                StDebounce: begin
                    if (row_match) begin
                        cnt_d = cnt_inc;
                        if (cnt_done) begin
                            state_d = StHeld;
                        end
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                        state_d   = StScan;
                    end
                end
                StHeld: begin
                    // Other rows in the locked column are deliberately ignored.
                    if (!row_hit) begin
                        cnt_d   = '0;
                        state_d = StRelease;
                    end
                end
                StRelease: begin
                    if (!row_hit) begin
                        cnt_d = cnt_inc;
                        if (cnt_done) begin
                            col_idx_d = col_idx_q + 2'd1;
                            state_d   = StScan;
                        end
                    end else begin
                        state_d = StHeld;
                    end
                end
                default: begin
                    state_d = StScan;
                end
            endcase
        end
    end

    always_comb begin
        key_valid_d = tick && (state_q == StDebounce) && row_match && cnt_done;
        key_code_d  = key_valid_d ? KeyMap[{row_idx_q, col_idx_q}] : key_code_q;
    end

    assign kp_if.col_keys  = 4'b0001 << col_idx_q;
    assign kp_if.key_code  = key_code_q;
    assign kp_if.key_valid = key_valid_q;
    assign kp_if.key_held  = (state_q == StHeld) || (state_q == StRelease);

endmodule

// File: tb/tb_keypad_controller.sv
// Randomized keypad stimulus checked against a tick-level behavioural model via a scoreboard.
module tb_keypad_controller;

    localparam int unsigned ScanDiv = 4;
    localparam int unsigned Dt      = 3;

    typedef struct {
        logic [3:0] code;
        int         cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic [15:0] phys = '0;  // bit r*4+c set = key at (row r, col c) physically pressed
    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    logic prev_valid = 1'b0;
    exp_t sb_q[$];

    // Reference model: which column the scanner is on and how far a press has progressed.
    int         m_col = 0;
    int         m_phase = 0;  // 0 searching, 1 confirming press, 2 pressed, 3 confirming release
    int         m_row = 0;
    int         m_run = 0;
    logic [3:0] m_code = 4'h0;
    logic       m_held = 1'b0;

    keypad_if kif();

    keypad_controller #(
        .ScanDiv       (ScanDiv),
        .DebounceTicks (Dt)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kp_if (kif.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive matrix: a driven column connects each pressed key to its row line.
    always_comb begin
        kif.rows = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (kif.col_keys[c] && phys[r*4+c]) kif.rows[r] = 1'b1;
            end
        end
    end

    function automatic logic [3:0] rows_at(input logic [15:0] p, input int col);
        logic [3:0] r;
        r = 4'b0000;
        for (int rr = 0; rr < 4; rr++) begin
            if (p[rr*4+col]) r[rr] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [3:0] key_val(input int idx);
        string map;
        byte   ch;
        map = "123A456B789CE0FD";
        ch  = map[idx];
        if (ch >= 8'h41) return 4'(ch - 8'h41 + 10);
        return 4'(ch - 8'h30);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every key_valid pulse must match the oldest expected key event.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset && kif.key_valid) begin
            check("valid_not_back_to_back", {31'd0, prev_valid}, 32'd0);
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_valid: got key_valid code %0h, expected none (cycle %0d)",
                         kif.key_code, cyc);
            end else begin
                e = sb_q.pop_front();
                check("valid_code", {28'd0, kif.key_code}, {28'd0, e.code});
                check("valid_cycle", cyc, e.cyc);
            end
        end
        prev_valid <= kif.key_valid;
    end

    task automatic model_tick(input logic [3:0] r);
        case (m_phase)
            0: begin
                if ($countones(r) == 1) begin
                    for (int i = 0; i < 4; i++) if (r[i]) m_row = i;
                    m_run   = 0;
                    m_phase = 1;
                end else begin
                    m_col = (m_col + 1) % 4;
                end
            end
            1: begin
                if (r == rows_at(16'(1) << (m_row * 4), 0)) begin
                    m_run++;
                    if (m_run == Dt) begin
                        m_phase = 2;
                        m_held  = 1'b1;
                        m_code  = key_val(m_row * 4 + m_col);
                        sb_q.push_back('{code: m_code, cyc: cyc});
                    end
                end else begin
                    m_col   = (m_col + 1) % 4;
                    m_phase = 0;
                end
            end
            2: begin
                if (!r[m_row]) begin
                    m_run   = 0;
                    m_phase = 3;
                end
            end
            default: begin
                if (!r[m_row]) begin
                    m_run++;
                    if (m_run == Dt) begin
                        m_phase = 0;
                        m_held  = 1'b0;
                        m_col   = (m_col + 1) % 4;
                    end
                end else begin
                    m_phase = 2;
                end
            end
        endcase
    endtask

    // One scan window: apply a key pattern, run to the tick edge, then compare.
    task automatic window(input logic [15:0] p);
        phys = p;
        repeat (ScanDiv) @(posedge clk);
        #1;
        check("no_missing_valid", sb_q.size(), 0);
        model_tick(rows_at(p, m_col));
        check("col_keys", {28'd0, kif.col_keys}, 32'd1 << m_col);
        check("key_held", {31'd0, kif.key_held}, {31'd0, m_held});
        check("key_code", {28'd0, kif.key_code}, {28'd0, m_code});
    endtask

    task automatic reset_check();
        check("rst_col_keys", {28'd0, kif.col_keys}, 32'h1);
        check("rst_key_code", {28'd0, kif.key_code}, 32'h0);
        check("rst_key_valid", {31'd0, kif.key_valid}, 32'h0);
        check("rst_key_held", {31'd0, kif.key_held}, 32'h0);
    endtask

    // Asynchronous reset partway into a window, released on a falling edge.
    task automatic pulse_reset(input logic [15:0] p);
        phys = p;
        repeat ($urandom_range(1, ScanDiv - 1)) @(posedge clk);
        #2 reset = 1'b0;
        #1 reset_check();
        @(negedge clk);
        reset   = 1'b1;
        m_phase = 0;
        m_col   = 0;
        m_run   = 0;
        m_code  = 4'h0;
        m_held  = 1'b0;
    endtask

    function automatic logic [15:0] key(input int r, input int c);
        return 16'(1) << (r * 4 + c);
    endfunction

    initial begin : stimulus
        logic [15:0] pat;
        #2 reset = 1'b0;
        #1 reset_check();
        @(negedge clk);
        reset = 1'b1;

        repeat (10) window('0);                              // idle rotation
        repeat (10) window(key(1, 2));                       // press '6'
        window('0);                                          // one-tick release bounce
        repeat (2) window(key(1, 2));
        repeat (4) window('0);                               // full release
        repeat (4) begin
            window(key(3, 1));                               // single-tick glitch
            window('0);
        end
        repeat (8) window(key(0, 0) | key(2, 0));            // two rows in one column
        repeat (4) window('0);

        pulse_reset('0);
        window(key(2, 0));                                   // detect in column 0
        pulse_reset(key(2, 0));                              // reset mid-debounce
        repeat (6) window(key(2, 0));
        pulse_reset(key(2, 0));                              // reset mid-held
        repeat (6) window(key(2, 0));
        repeat (4) window('0);

        pat = '0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) < 3) begin
                pulse_reset(pat);
            end else begin
                if ($urandom_range(0, 99) >= 85) begin
                    case ($urandom_range(0, 9))
                        0, 1, 2, 3: pat = '0;
                        8:       pat = key($urandom_range(0, 3), $urandom_range(0, 3)) |
                                       key($urandom_range(0, 3), $urandom_range(0, 3));
                        default: pat = key($urandom_range(0, 3), $urandom_range(0, 3));
                    endcase
                end
                window(pat);
            end
        end

        @(negedge clk);
        #1 check("scoreboard_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
